// File: rtl/baseaddr_rd_select.sv
// baseaddr_rd_select: read-side buffer selector for the 5-buffer VDMA ring.
// Claims the newest completed write buffer on each read frame start.
//
// Ports:
//   rclk             single clock, rising edge
//   rrst             synchronous active-high reset
//   enable           gates rd_vs / rd_hs edge detection
//   rd_vs, rd_hs     read sync levels, already in the rclk domain
//   last_next_point  one-hot newest completed write buffer
//   wr_current_point one-hot buffer the writer currently owns
//   rd_curr_point    one-hot buffer owned by this reader (0 = none)
//   frame_base       byte base address of the owned buffer
//   line_addr        start address of the current line
//   frame_start      pulse when frame_base / line_addr reload
//   frame_repeat     pulse when no new buffer was claimed
//   sel_err          pulse when last_next_point was not one-hot
module baseaddr_rd_select #(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] FRAME_BYTES = 32'h0080_0000,
   parameter logic [ADDR_W-1:0] LINE_BYTES  = 32'h0000_1000
) (
   input  logic              rclk,
   input  logic              rrst,
   input  logic              enable,
   input  logic              rd_vs,
   input  logic              rd_hs,
   input  logic [4:0]        last_next_point,
   input  logic [4:0]        wr_current_point,
   output logic [4:0]        rd_curr_point,
   output logic [ADDR_W-1:0] frame_base,
   output logic [ADDR_W-1:0] line_addr,
   output logic              frame_start,
   output logic              frame_repeat,
   output logic              sel_err
);

   // gated sync levels and edge detectors
   logic vs_gated;
   logic hs_gated;
   logic vs_q;
   logic hs_q;
   logic vs_rise;
   logic hs_rise;

   // pipeline flags between detection, selection and reload
   logic sel_pend;
   logic reload_pend;
   logic step_pend;

   // candidate / writer snapshot taken in the vs_rise cycle
   logic [4:0] cand_q;
   logic [4:0] wr_q;

   logic              cand_ok;
   logic              cand_busy;
   logic [2:0]        idx;
   logic [ADDR_W-1:0] next_base;

   assign vs_gated = rd_vs & enable;
   assign hs_gated = rd_hs & enable;

   // exactly one bit set: nonzero and clearing the lowest bit leaves zero
   assign cand_ok   = (cand_q != 5'd0) &&
                      ((cand_q & (cand_q - 5'd1)) == 5'd0);
   assign cand_busy = |(cand_q & wr_q);

   always_comb begin
      idx = 3'd0;
      case (rd_curr_point)
         5'b00001: idx = 3'd0;
         5'b00010: idx = 3'd1;
         5'b00100: idx = 3'd2;
         5'b01000: idx = 3'd3;
         5'b10000: idx = 3'd4;
         default:  idx = 3'd0;
      endcase
   end

   // wraps modulo 2^ADDR_W by construction
   assign next_base = BASE_ADDR + (ADDR_W'(idx) * FRAME_BYTES);

   // edge detection
   always_ff @(posedge rclk) begin
      if (rrst) begin
         vs_q    <= 1'b0;
         hs_q    <= 1'b0;
         vs_rise <= 1'b0;
         hs_rise <= 1'b0;
      end else begin
         vs_q    <= vs_gated;
         hs_q    <= hs_gated;
         vs_rise <= vs_gated & ~vs_q;
         hs_rise <= hs_gated & ~hs_q;
      end
   end

   // candidate capture stage
   always_ff @(posedge rclk) begin
      if (rrst) begin
         sel_pend  <= 1'b0;
         step_pend <= 1'b0;
         cand_q    <= 5'd0;
         wr_q      <= 5'd0;
      end else begin
         sel_pend  <= vs_rise;
         step_pend <= hs_rise;
         if (vs_rise) begin
            cand_q <= last_next_point;
            wr_q   <= wr_current_point;
         end
      end
   end

   // buffer selection
   always_ff @(posedge rclk) begin
      if (rrst) begin
         rd_curr_point <= 5'd0;
         frame_repeat  <= 1'b0;
         sel_err       <= 1'b0;
         reload_pend   <= 1'b0;
      end else begin
         frame_repeat <= 1'b0;
         sel_err      <= 1'b0;
         reload_pend  <= sel_pend;
         if (sel_pend) begin
            if (!cand_ok) begin
               sel_err      <= 1'b1;
               frame_repeat <= 1'b1;
            end else if (cand_busy) begin
               frame_repeat <= 1'b1;
            end else if (cand_q == rd_curr_point) begin
               frame_repeat <= 1'b1;
            end else begin
               rd_curr_point <= cand_q;
            end
         end
      end
   end

   // address generation: a frame reload overrides a same-cycle line step
   always_ff @(posedge rclk) begin
      if (rrst) begin
         frame_base  <= BASE_ADDR;
         line_addr   <= BASE_ADDR;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (reload_pend) begin
            frame_base  <= next_base;
            line_addr   <= next_base;
            frame_start <= 1'b1;
         end else if (step_pend) begin
            line_addr <= line_addr + LINE_BYTES;
         end
      end
   end

endmodule

// File: doc/baseaddr_rd_select.md
# baseaddr_rd_select

Read-side frame-buffer selector for the 5-buffer VDMA rotation. On each read-frame start it claims the newest completed write buffer, reported by the write loop's `last_next_point`, unless the writer currently owns that buffer. It drives its one-hot claim back to the write loop as one of the `rdN_curr_point` inputs. It also turns the claim into a byte base address and a per-line read address for the read master.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `BASE_ADDR`, 32'h0000_0000: byte address of buffer 0.
- `FRAME_BYTES`, 32'h0080_0000: stride between buffers.
- `LINE_BYTES`, 32'h0000_1000: stride between lines.

Ports (clock and reset first):
- `rclk`  in  1  single clock; every register is clocked on its rising edge.
- `rrst`  in  1  reset, synchronous and active-high.
- `enable`  in  1  gates `rd_vs` and `rd_hs` edge detection.
- `rd_vs`  in  1  read vsync level, already synchronous to `rclk`.
- `rd_hs`  in  1  read hsync level, already synchronous to `rclk`.
- `last_next_point`  in  5  one-hot, newest completed write buffer.
- `wr_current_point`  in  5  one-hot, buffer the writer currently owns.
- `rd_curr_point`  out  5  one-hot, buffer this reader owns (0 = none).
- `frame_base`  out  ADDR_W  base address of the owned buffer.
- `line_addr`  out  ADDR_W  start address of the current line.
- `frame_start`  out  1  one-cycle pulse when `frame_base` and `line_addr` reload.
- `frame_repeat`  out  1  one-cycle pulse when no new buffer was claimed.
- `sel_err`  out  1  one-cycle pulse when `last_next_point` is not one-hot.

## Operation
- **Edge detect:** `vs_q <= rd_vs & enable` and `hs_q <= rd_hs & enable`.
  - `vs_rise` is registered: it is high for one cycle when `(rd_vs & enable) & ~vs_q`.
  - `hs_rise` is formed the same way.
- **Selection on `vs_rise`:** let `cand = last_next_point`.
  - If `cand` is not one-hot (zero or multi-hot): hold `rd_curr_point`; pulse `sel_err` and `frame_repeat`.
  - Else if `cand & wr_current_point` is nonzero: hold; pulse `frame_repeat`.
  - Else if `cand == rd_curr_point` (no new frame): hold; pulse `frame_repeat`.
  - Else: `rd_curr_point <= cand`.
  - Whichever branch is taken, the frame reload below always follows.
- **Index:** one-hot to 3-bit index, `00001`→0 through `10000`→4. If `rd_curr_point` is zero, the index is 0.
- **Address:** `frame_base <= BASE_ADDR + idx*FRAME_BYTES`, computed in ADDR_W bits, truncating modulo 2^ADDR_W. `line_addr` reloads with the same value, and `frame_start` pulses with it.
- **Line step:** on `hs_rise`, `line_addr <= line_addr + LINE_BYTES` (wraps modulo 2^ADDR_W).
  - If `hs_rise` coincides with the reload, the reload wins and the step is dropped.
  - There is no line limit; the lines-per-frame count belongs to the read master.
- **Enable low:** no edges are detected, and all outputs hold. When `enable` rises while `rd_vs` is high, that counts as a `vs_rise`.

## Timing
- **Reset values:** after a cycle with `rrst` high, all of the following hold:
  - `rd_curr_point=5'b00000`
  - `frame_base=BASE_ADDR`
  - `line_addr=BASE_ADDR`
  - `frame_start`, `frame_repeat`, `sel_err` = 0
  - `vs_q=hs_q=0`
- **Reset mid-frame:** reset mid-frame abandons the claim immediately, which releases the buffer to the writer.
- **Frame latency:** `rd_vs` first sampled high at edge N.
  - `vs_rise` is high during N+1.
  - `rd_curr_point`, `frame_repeat` and `sel_err` update at edge N+2.
  - `frame_base`, `line_addr` and `frame_start` update at edge N+3.
- **Line latency:** `rd_hs` sampled high at edge M gives a `line_addr` step at edge M+2.
- **Input sampling:** `last_next_point` and `wr_current_point` are sampled in the `vs_rise` cycle only.
- **Holding `rd_vs` high:** it yields one selection; a new selection needs a low-then-high transition.
- **Interaction with the write loop:** the claimed buffer is never equal to `wr_current_point` as sampled. The write loop then excludes `rd_curr_point` from its next choice, so the reader and writer never share a buffer.

## Test plan
- **Reset, then normal claim:** reset, then `vs` rise with `last_next_point=00100`, `wr_current_point=00001`.
  - `rd_curr_point=00100` at N+2.
  - `frame_base=line_addr=BASE+2*FRAME_BYTES=32'h0100_0000` and `frame_start=1` at N+3.
- **Writer collision:** `last_next_point=01000`, `wr_current_point=01000`, reader holding `00100` → `rd_curr_point` stays `00100`, `frame_repeat=1` for one cycle, `frame_base` reloads to `32'h0100_0000`.
- **Invalid candidate:** `last_next_point=00000`, then `00110` on the next frame → both frames pulse `sel_err` and `frame_repeat`; `rd_curr_point` is unchanged.
- **Line stepping:** after claiming `10000`, give 3 `hs` rises → `line_addr=32'h0200_3000`. Then assert an `hs` rise together with the next `vs` reload → `line_addr` equals the new base and the step is dropped.
- **Enable gating and wrap:**
  - `enable=0` across vs/hs toggles → no change on any output.
  - Raising `enable` while `vs` is high → one selection.
  - `ADDR_W=32`, `BASE_ADDR=32'hFFFF_F000`, 2 hs rises → `line_addr=32'h0000_1000`.
- **Reset mid-frame:** assert `rrst` while holding `00010` → `rd_curr_point=00000` and `line_addr=BASE_ADDR` on the next edge.
